// File: rtl/pipe_cla_add_sub.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split across SEGMENTS
// registered CLA stages under a global valid/ready stall, with optional signed saturation.
module pipe_cla_add_sub #(
    parameter int WIDTH    = 16,
    parameter int SEGMENTS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] Bin,
    input  logic             Cin,
    input  logic             isSub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned SEGW = WIDTH / SEGMENTS;
    localparam int unsigned LAST = SEGMENTS - 1;

    // Stage k register holds operands, partial sum (bits below the next segment) and carry.
    logic             rv   [SEGMENTS];
    logic [WIDTH-1:0] ra   [SEGMENTS];
    logic [WIDTH-1:0] rb   [SEGMENTS];
    logic [WIDTH-1:0] rs   [SEGMENTS];
    logic             rc   [SEGMENTS];
    logic             rsat [SEGMENTS];

    logic             nv   [SEGMENTS];
    logic [WIDTH-1:0] na   [SEGMENTS];
    logic [WIDTH-1:0] nb   [SEGMENTS];
    logic [WIDTH-1:0] ns   [SEGMENTS];
    logic             nc   [SEGMENTS];
    logic             nsat [SEGMENTS];

    logic [WIDTH-1:0] beff;
    logic [SEGW:0]    seg_r;
    logic             novfl;
    logic             nzero;
    logic             nneg;
    logic             adv;

    function automatic logic [SEGW:0] cla_seg(input logic [SEGW-1:0] a,
                                              input logic [SEGW-1:0] b,
                                              input logic            ci);
        logic [SEGW-1:0] g;
        logic [SEGW-1:0] p;
        logic [SEGW:0]   c;
        logic            t;
        logic            pp;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        // Flat lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
        for (int unsigned i = 0; i < SEGW; i++) begin
            t  = g[i];
            pp = p[i];
            for (int unsigned j = 0; j < i; j++) begin
                t  = t | (pp & g[i-1-j]);
                pp = pp & p[i-1-j];
            end
            c[i+1] = t | (pp & ci);
        end
        return {c[SEGW], p ^ c[SEGW-1:0]};
    endfunction

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = rv[LAST];
    assign S         = rs[LAST];
    assign Cout      = rc[LAST];

    always_comb begin
        beff  = isSub ? ~Bin : Bin;
        seg_r = cla_seg(A[SEGW-1:0], beff[SEGW-1:0], isSub ? ~Cin : Cin);
        nv[0]   = in_valid;
        na[0]   = A;
        nb[0]   = beff;
        ns[0]   = '0;
        ns[0][SEGW-1:0] = seg_r[SEGW-1:0];
        nc[0]   = seg_r[SEGW];
        nsat[0] = sat;
        for (int unsigned s = 1; s < SEGMENTS; s++) begin
            seg_r   = cla_seg(ra[s-1][s*SEGW +: SEGW], rb[s-1][s*SEGW +: SEGW], rc[s-1]);
            nv[s]   = rv[s-1];
            na[s]   = ra[s-1];
            nb[s]   = rb[s-1];
            ns[s]   = rs[s-1];
            ns[s][s*SEGW +: SEGW] = seg_r[SEGW-1:0];
            nc[s]   = seg_r[SEGW];
            nsat[s] = rsat[s-1];
        end
        // The output register stores the final (possibly saturated) result.
        novfl = (na[LAST][WIDTH-1] == nb[LAST][WIDTH-1]) &&
                (ns[LAST][WIDTH-1] != na[LAST][WIDTH-1]);
        if (nsat[LAST] && novfl) begin
            ns[LAST] = na[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
        nzero = (ns[LAST] == '0);
        nneg  = ns[LAST][WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rv   <= '{default: 1'b0};
            ra   <= '{default: '0};
            rb   <= '{default: '0};
            rs   <= '{default: '0};
            rc   <= '{default: 1'b0};
            rsat <= '{default: 1'b0};
            ovfl <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (adv) begin
            rv   <= nv;
            ra   <= na;
            rb   <= nb;
            rs   <= ns;
            rc   <= nc;
            rsat <= nsat;
            ovfl <= novfl;
            zero <= nzero;
            neg  <= nneg;
        end
    end

endmodule

// File: tb/tb_pipe_cla_add_sub.sv
// Bench for pipe_cla_add_sub: three configurations (32/8, 16/4, 8/1) driven from one
// operation list, each with its own source pointer and expected-result queue.
module tb_pipe_cla_add_sub;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic        sat;
        logic        has16;
        logic [35:0] exp16;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        out_ready;
    logic        iv [3];
    logic        ir [3];
    logic        ov [3];
    logic [31:0] ta [3];
    logic [31:0] tbv [3];
    logic        tcin [3];
    logic        tsub [3];
    logic        tsat [3];
    logic        co [3];
    logic        vo [3];
    logic        zo [3];
    logic        ng [3];
    logic [31:0] s32;
    logic [15:0] s16;
    logic [7:0]  s8;

    int          checks = 0;
    int          errors = 0;
    op_t         ops[$];
    int unsigned ptr [3];
    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [35:0] q2[$];
    logic        stalled [3];
    logic [35:0] held [3];
    logic        acc [3];
    logic        ovs [3];
    logic        irs [3];
    logic [35:0] obsv [3];

    pipe_cla_add_sub #(.WIDTH(32), .SEGMENTS(8)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .A(ta[0]), .Bin(tbv[0]), .Cin(tcin[0]), .isSub(tsub[0]), .sat(tsat[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .S(s32),
        .Cout(co[0]), .ovfl(vo[0]), .zero(zo[0]), .neg(ng[0]));

    pipe_cla_add_sub #(.WIDTH(16), .SEGMENTS(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .A(ta[1][15:0]), .Bin(tbv[1][15:0]), .Cin(tcin[1]), .isSub(tsub[1]), .sat(tsat[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .S(s16),
        .Cout(co[1]), .ovfl(vo[1]), .zero(zo[1]), .neg(ng[1]));

    pipe_cla_add_sub #(.WIDTH(8), .SEGMENTS(1)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .A(ta[2][7:0]), .Bin(tbv[2][7:0]), .Cin(tcin[2]), .isSub(tsub[2]), .sat(tsat[2]),
        .out_valid(ov[2]), .out_ready(out_ready), .S(s8),
        .Cout(co[2]), .ovfl(vo[2]), .zero(zo[2]), .neg(ng[2]));

    function automatic int wid_of(input int i);
        case (i)
            0:       return 32;
            1:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int seg_of(input int i);
        case (i)
            0:       return 8;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] s_of(input int i);
        case (i)
            0:       return s32;
            1:       return {16'h0, s16};
            default: return {24'h0, s8};
        endcase
    endfunction

    // Reference: exact integer arithmetic on the signed/unsigned operand values.
    function automatic logic [35:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub, input logic sat);
        longint m, ua, ub, sa, sb, ex, mx, mn, r, ci;
        logic   c, v;
        m  = (longint'(1) << w) - 1;
        mx = m >> 1;
        mn = -mx - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (ua > mx) ? ua - (m + 1) : ua;
        sb = (ub > mx) ? ub - (m + 1) : ub;
        ci = longint'(cin);
        if (sub) begin
            ex = sa - sb - ci;
            c  = (ua >= ub + ci);
        end else begin
            ex = sa + sb + ci;
            c  = ((ua + ub + ci) > m);
        end
        v = (ex > mx) || (ex < mn);
        r = (sat && v) ? ((sa < 0) ? mn : mx) : ex;
        r = r & m;
        return {r[31:0], c, v, (r == 0), r[w-1]};
    endfunction

    function automatic logic [35:0] expected(input int i, input op_t op);
        if (i == 1 && op.has16) return op.exp16;
        return model(wid_of(i), op.a, op.b, op.cin, op.sub, op.sat);
    endfunction

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic sub, input logic sat, input logic [15:0] s,
                               input logic c, input logic v, input logic z, input logic n);
        op_t o;
        o.a = a; o.b = b; o.cin = cin; o.sub = sub; o.sat = sat;
        o.has16 = 1'b1;
        o.exp16 = {16'h0, s, c, v, z, n};
        return o;
    endfunction

    function automatic op_t rnd();
        op_t o;
        o.a = $urandom; o.b = $urandom;
        o.cin = 1'($urandom % 2); o.sub = 1'($urandom % 2); o.sat = 1'($urandom % 2);
        o.has16 = 1'b0;
        o.exp16 = '0;
        return o;
    endfunction

    function automatic int pending();
        int n;
        n = q0.size() + q1.size() + q2.size();
        for (int i = 0; i < 3; i++) n += ops.size() - int'(ptr[i]);
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int i, input logic [35:0] e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int i, output logic ok, output logic [35:0] e);
        ok = 1'b0;
        e  = '0;
        case (i)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // One clock: drive from each source pointer, sample mid-low phase, then cross an edge.
    task automatic tick();
        logic        ok;
        logic [35:0] e;
        for (int i = 0; i < 3; i++) begin
            if (ptr[i] < ops.size()) begin
                iv[i]   = 1'b1;
                ta[i]   = ops[ptr[i]].a;
                tbv[i]  = ops[ptr[i]].b;
                tcin[i] = ops[ptr[i]].cin;
                tsub[i] = ops[ptr[i]].sub;
                tsat[i] = ops[ptr[i]].sat;
            end else begin
                iv[i] = 1'b0;
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            obsv[i] = {s_of(i), co[i], vo[i], zo[i], ng[i]};
            ovs[i]  = ov[i];
            irs[i]  = ir[i];
            acc[i]  = 1'b0;
            if (!rst) begin
                if (stalled[i])
                    check($sformatf("hold_w%0d", wid_of(i)), {ov[i], obsv[i]}, {1'b1, held[i]});
                if (ov[i] && out_ready) begin
                    pop_exp(i, ok, e);
                    check($sformatf("unexpected_out_w%0d", wid_of(i)), 64'(ok), 64'd1);
                    if (ok) check($sformatf("result_w%0d", wid_of(i)), obsv[i], e);
                end
                stalled[i] = ov[i] && !out_ready;
                held[i]    = obsv[i];
                acc[i]     = iv[i] && ir[i];
                if (acc[i]) push_exp(i, expected(i, ops[ptr[i]]));
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) stalled[i] = 1'b0;
            else if (acc[i]) ptr[i]++;
        end
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete();
        end
    endtask

    task automatic new_ops();
        ops.delete();
        for (int i = 0; i < 3; i++) ptr[i] = 0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (pending() > 0 && n < limit) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(pending()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ta[i] = '0; tbv[i] = '0;
            tcin[i] = 1'b0; tsub[i] = 1'b0; tsat[i] = 1'b0;
            stalled[i] = 1'b0; held[i] = '0; ptr[i] = 0;
        end
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_out_valid_w%0d", wid_of(i)), 64'(ovs[i]), 64'd0);
            check($sformatf("rst_in_ready_w%0d", wid_of(i)), 64'(irs[i]), 64'd1);
            check($sformatf("rst_bundle_w%0d", wid_of(i)), 64'(obsv[i]), 64'd0);
        end

        // Latency: single op, out_valid exactly SEGMENTS samples after the accept edge
        new_ops();
        ops.push_back(mk(32'd10, 32'd5, 1'b0, 1'b0, 1'b0, 16'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        for (int i = 0; i < 3; i++) check($sformatf("accept_w%0d", wid_of(i)), 64'(acc[i]), 64'd1);
        for (int j = 1; j <= 9; j++) begin
            tick();
            for (int i = 0; i < 3; i++)
                check($sformatf("latency_w%0d_c%0d", wid_of(i), j), 64'(ovs[i]),
                      64'(j == seg_of(i)));
        end

        // Directed arithmetic, overflow and saturation corners, streamed back-to-back
        new_ops();
        ops.push_back(mk(32'd10,        32'd5,        1'b0, 1'b1, 1'b0, 16'd5,      1'b1, 1'b0, 1'b0, 1'b0));
        ops.push_back(mk(32'hFFFFFFF6,  32'd5,        1'b0, 1'b1, 1'b0, 16'hFFF1,   1'b1, 1'b0, 1'b0, 1'b1));
        ops.push_back(mk(32'd10,        32'hFFFFFFFB, 1'b0, 1'b1, 1'b0, 16'd15,     1'b0, 1'b0, 1'b0, 1'b0));
        ops.push_back(mk(32'hFFFFFFF6,  32'hFFFFFFFB, 1'b1, 1'b0, 1'b0, 16'hFFF2,   1'b1, 1'b0, 1'b0, 1'b1));
        ops.push_back(mk(32'h00007FFF,  32'd1,        1'b0, 1'b0, 1'b0, 16'h8000,   1'b0, 1'b1, 1'b0, 1'b1));
        ops.push_back(mk(32'h00007FFF,  32'd1,        1'b0, 1'b0, 1'b1, 16'h7FFF,   1'b0, 1'b1, 1'b0, 1'b0));
        ops.push_back(mk(32'hFFFF8000,  32'd1,        1'b0, 1'b1, 1'b1, 16'h8000,   1'b1, 1'b1, 1'b0, 1'b1));
        ops.push_back(mk(32'd0,         32'd0,        1'b0, 1'b1, 1'b0, 16'h0000,   1'b1, 1'b0, 1'b1, 1'b0));
        drain(100);

        // Eight random ops with a three-cycle downstream stall mid-stream
        new_ops();
        for (int k = 0; k < 8; k++) ops.push_back(rnd());
        for (int t = 0; t < 8; t++) begin
            out_ready = (t < 5 || t > 7);
            tick();
            if (t >= 5 && t <= 7) begin
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("stall_out_valid_w%0d_t%0d", wid_of(i), t), 64'(ovs[i]),
                          64'(seg_of(i) <= 5));
                    check($sformatf("stall_in_ready_w%0d_t%0d", wid_of(i), t), 64'(irs[i]),
                          64'(seg_of(i) > 5));
                end
            end
        end
        out_ready = 1'b1;
        drain(100);

        // Longer random soak with random backpressure
        new_ops();
        for (int k = 0; k < 40; k++) ops.push_back(rnd());
        for (int t = 0; t < 400 && pending() > 0; t++) begin
            out_ready = (($urandom % 4) != 0);
            tick();
        end
        out_ready = 1'b1;
        drain(100);

        // Reset with ops in flight and a competing accept; nothing may emerge afterwards
        new_ops();
        for (int k = 0; k < 4; k++) ops.push_back(rnd());
        repeat (3) tick();
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        new_ops();
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post_rst_out_valid_w%0d", wid_of(i)), 64'(ovs[i]), 64'd0);
            check($sformatf("post_rst_in_ready_w%0d", wid_of(i)), 64'(irs[i]), 64'd1);
        end
        for (int j = 0; j < 11; j++) begin
            tick();
            for (int i = 0; i < 3; i++)
                check($sformatf("stale_w%0d_c%0d", wid_of(i), j), 64'(ovs[i]), 64'd0);
        end

        // Pipeline still usable after the reset
        ops.push_back(mk(32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
        ops.push_back(mk(32'h00007FFF, 32'd1, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0));
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
